// File: rtl/axi_mgr_arb_if.sv
// Requester command/response bundle plus the single-beat AXI manager channels of axi_mgr_arb.
// The master modport is the arbiter's view; slave is the requester/subordinate side.
interface axi_mgr_arb_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic                    m_axi_wlast;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic                    m_axi_rlast;
  logic [1:0]              m_axi_rresp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wvalid, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rvalid, m_axi_rlast, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wvalid, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rvalid, m_axi_rlast, m_axi_rresp,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_mgr_arb.sv
// Round-robin arbiter for two requesters sharing one single-beat AXI manager port.
// Exactly one transaction is outstanding; a per-transaction timeout aborts with resp 2'b11.
module axi_mgr_arb #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           s_axi_clk,
  input logic           s_axi_resetn,
  axi_mgr_arb_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TmoLast =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrResp,
    StRdAddr,
    StRdData
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_owner;
  logic                  r_last_grant;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_b_done;
  logic [1:0]            r_bresp;
  logic [CntW-1:0]       r_tmo_cnt;
  logic [1:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  logic                  w_grant_vld;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_tmo;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_b_done;
  logic [1:0]            w_bresp;
  logic                  w_finish;
  logic                  w_load_rdata;
  logic [1:0]            w_rsp_code;
  logic                  w_unused;

  // rlast carries no information for single-beat reads.
  assign w_unused = bus.m_axi_rlast;

  // Arbitration: a lone requester wins outright; on contention the one not granted last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    unique case (bus.req_valid)
      2'b00: ;
      2'b01: w_grant_vld = 1'b1;
      2'b10: begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b1;
      end
      2'b11: begin
        w_grant_vld = 1'b1;
        w_grant     = ~r_last_grant;
      end
    endcase
  end

  assign w_accept      = (r_state == StIdle) && w_grant_vld;
  assign bus.req_ready = (w_accept && s_axi_resetn) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  // AW and W retire independently; B is accepted throughout the write.
  assign w_awvalid = (r_state == StWrAddr) && !r_aw_done;
  assign w_wvalid  = (r_state == StWrAddr) && !r_w_done;
  assign w_bready  = (r_state == StWrAddr) || (r_state == StWrResp);
  assign w_arvalid = (r_state == StRdAddr);
  assign w_rready  = (r_state == StRdAddr) || (r_state == StRdData);

  assign w_aw_hs = w_awvalid && bus.m_axi_awready;
  assign w_w_hs  = w_wvalid && bus.m_axi_wready;
  assign w_b_hs  = w_bready && bus.m_axi_bvalid;
  assign w_ar_hs = w_arvalid && bus.m_axi_arready;
  assign w_r_hs  = w_rready && bus.m_axi_rvalid;

  assign w_aw_done = r_aw_done || w_aw_hs;
  assign w_w_done  = r_w_done || w_w_hs;
  assign w_b_done  = r_b_done || w_b_hs;
  assign w_bresp   = r_b_done ? r_bresp : bus.m_axi_bresp;

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_state != StIdle) && (r_tmo_cnt == TmoLast);

  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awvalid = w_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wvalid  = w_wvalid;
  assign bus.m_axi_wlast   = w_wvalid;
  assign bus.m_axi_bready  = w_bready;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arvalid = w_arvalid;
  assign bus.m_axi_rready  = w_rready;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_resp  = r_rsp_resp;

  // Normal completion is checked before the timeout so a same-cycle response wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_finish     = 1'b0;
    w_load_rdata = 1'b0;
    w_rsp_code   = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = bus.req_write[w_grant] ? StWrAddr : StRdAddr;
        end
      end
      StWrAddr: begin
        if (w_aw_done && w_w_done && w_b_done) begin
          w_finish    = 1'b1;
          w_rsp_code  = w_bresp;
          w_state_nxt = StIdle;
        end else if (w_tmo) begin
          w_finish    = 1'b1;
          w_rsp_code  = 2'b11;
          w_state_nxt = StIdle;
        end else if (w_aw_done && w_w_done) begin
          w_state_nxt = StWrResp;
        end
      end
      StWrResp: begin
        if (w_b_hs) begin
          w_finish    = 1'b1;
          w_rsp_code  = bus.m_axi_bresp;
          w_state_nxt = StIdle;
        end else if (w_tmo) begin
          w_finish    = 1'b1;
          w_rsp_code  = 2'b11;
          w_state_nxt = StIdle;
        end
      end
      StRdAddr: begin
        if (w_r_hs) begin
          w_finish     = 1'b1;
          w_load_rdata = 1'b1;
          w_rsp_code   = bus.m_axi_rresp;
          w_state_nxt  = StIdle;
        end else if (w_tmo) begin
          w_finish    = 1'b1;
          w_rsp_code  = 2'b11;
          w_state_nxt = StIdle;
        end else if (w_ar_hs) begin
          w_state_nxt = StRdData;
        end
      end
      StRdData: begin
        if (w_r_hs) begin
          w_finish     = 1'b1;
          w_load_rdata = 1'b1;
          w_rsp_code   = bus.m_axi_rresp;
          w_state_nxt  = StIdle;
        end else if (w_tmo) begin
          w_finish    = 1'b1;
          w_rsp_code  = 2'b11;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_b_done     <= 1'b0;
      r_bresp      <= 2'b00;
      r_tmo_cnt    <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= '0;
      r_rsp_resp   <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 2'b00;
      if (w_accept) begin
        r_addr       <= w_grant ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.req_addr[ADDR_WIDTH-1:0];
        r_wdata      <= w_grant ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : bus.req_wdata[DATA_WIDTH-1:0];
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_aw_done    <= 1'b0;
        r_w_done     <= 1'b0;
        r_b_done     <= 1'b0;
        r_tmo_cnt    <= '0;
      end else if (r_state != StIdle) begin
        r_tmo_cnt <= r_tmo_cnt + CntW'(1);
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      // An early B (before both AW and W retire) is parked until the write can close.
      if (w_b_hs && (r_state == StWrAddr)) begin
        r_b_done <= 1'b1;
        r_bresp  <= bus.m_axi_bresp;
      end
      if (w_finish) begin
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        r_rsp_resp  <= w_rsp_code;
      end
      if (w_load_rdata) begin
        r_rsp_rdata <= bus.m_axi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_mgr_arb.sv
// Directed bench for axi_mgr_arb against a small CSR subordinate model whose
// registers reset to (address ^ 0x1C).
module tb_axi_mgr_arb;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_mgr_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_mgr_arb #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .s_axi_clk   (clk),
    .s_axi_resetn(rst_n),
    .bus         (bus)
  );

  // Subordinate model knobs and state.
  logic       sub_awready;
  logic       sub_arready;
  int         sub_w_stall;
  logic       sub_b_block;
  int         sub_cnt;
  logic       sub_aw_seen, sub_w_seen;
  logic [7:0] sub_awaddr, sub_wdata;
  logic       sub_bvalid, sub_rvalid;
  logic [7:0] sub_rdata;
  logic [7:0] mem [256];
  logic       sub_aw_hs, sub_w_hs, sub_ar_hs;

  assign bus.m_axi_awready = sub_awready;
  assign bus.m_axi_wready  = (sub_cnt >= sub_w_stall);
  assign bus.m_axi_arready = sub_arready;
  assign bus.m_axi_bvalid  = sub_bvalid;
  assign bus.m_axi_bresp   = 2'b00;
  assign bus.m_axi_rvalid  = sub_rvalid;
  assign bus.m_axi_rdata   = sub_rdata;
  assign bus.m_axi_rresp   = 2'b00;
  assign bus.m_axi_rlast   = 1'b1;

  assign sub_aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
  assign sub_w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
  assign sub_ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt     <= 0;
      sub_aw_seen <= 1'b0;
      sub_w_seen  <= 1'b0;
      sub_awaddr  <= 8'h00;
      sub_wdata   <= 8'h00;
      sub_bvalid  <= 1'b0;
      sub_rvalid  <= 1'b0;
      sub_rdata   <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
    end else begin
      if (sub_aw_hs) begin
        sub_aw_seen <= 1'b1;
        sub_awaddr  <= bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid) sub_cnt <= sub_w_hs ? 0 : sub_cnt + 1;
      if (sub_w_hs) begin
        sub_w_seen <= 1'b1;
        sub_wdata  <= bus.m_axi_wdata;
      end
      if (sub_bvalid && bus.m_axi_bready) sub_bvalid <= 1'b0;
      if ((sub_aw_seen || sub_aw_hs) && (sub_w_seen || sub_w_hs)) begin
        sub_aw_seen <= 1'b0;
        sub_w_seen  <= 1'b0;
        mem[sub_aw_hs ? bus.m_axi_awaddr : sub_awaddr] <= sub_w_hs ? bus.m_axi_wdata : sub_wdata;
        if (!sub_b_block) sub_bvalid <= 1'b1;
      end
      if (sub_rvalid && bus.m_axi_rready) sub_rvalid <= 1'b0;
      if (sub_ar_hs) begin
        sub_rvalid <= 1'b1;
        sub_rdata  <= mem[bus.m_axi_araddr];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each tb cycle window starts 3 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  int         wait_c;
  logic [1:0] exp_g;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    sub_awready   = 1'b1;
    sub_arready   = 1'b1;
    sub_w_stall   = 0;
    sub_b_block   = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) cyc();
    #1;
    chk("rst_axi_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                           bus.m_axi_bready, bus.m_axi_rready}, 5'b0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata}, 12'h000);
    rst_n = 1'b1;
    cyc();

    // Req0 write 0x10 <= 0xA5, zero-wait subordinate.
    bus.req_write = 2'b01;
    bus.req_addr  = {8'h00, 8'h10};
    bus.req_wdata = {8'h00, 8'hA5};
    bus.req_valid = 2'b01;
    #1;
    chk("wr_req_ready", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("wr_valids_t1", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast,
                         bus.m_axi_bready, bus.m_axi_arvalid}, 5'b11110);
    chk("wr_awaddr", bus.m_axi_awaddr, 8'h10);
    chk("wr_wdata", bus.m_axi_wdata, 8'hA5);
    chk("wr_ready_busy", bus.req_ready, 2'b00);
    cyc();
    chk("wr_no_rsp_t2", bus.rsp_valid, 2'b00);
    cyc();
    chk("wr_rsp_t3", bus.rsp_valid, 2'b01);
    chk("wr_resp", bus.rsp_resp, 2'b00);
    cyc();
    chk("wr_rsp_pulse", bus.rsp_valid, 2'b00);

    // Req1 read 0x20 -> reset pattern 0x20 ^ 0x1C = 0x3C.
    bus.req_write = 2'b00;
    bus.req_addr  = {8'h20, 8'h00};
    bus.req_valid = 2'b10;
    #1;
    chk("rd_req_ready", bus.req_ready, 2'b10);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("rd_valids_t1", {bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awvalid}, 3'b110);
    chk("rd_araddr", bus.m_axi_araddr, 8'h20);
    cyc();
    cyc();
    chk("rd_rsp_owner", bus.rsp_valid, 2'b10);
    chk("rd_rdata", bus.rsp_rdata, 8'h3C);
    chk("rd_resp", bus.rsp_resp, 2'b00);

    // Both requesters valid: req0 writes 0x30, req1 reads 0x10 (0xA5 from above).
    bus.req_write = 2'b01;
    bus.req_addr  = {8'h10, 8'h30};
    bus.req_wdata = {8'h00, 8'h5A};
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      wait_c = 0;
      while (bus.req_ready == 2'b00 && wait_c < 10) begin
        cyc();
        #1;
        wait_c++;
      end
      chk("fair_grant", bus.req_ready, exp_g);
      cyc();
      if (n == 3) bus.req_valid = 2'b00;
      #1;
      wait_c = 0;
      while (bus.rsp_valid == 2'b00 && wait_c < 10) begin
        chk("fair_one_outstanding", bus.req_ready, 2'b00);
        cyc();
        #1;
        wait_c++;
      end
      chk("fair_rsp_owner", bus.rsp_valid, exp_g);
      if (exp_g == 2'b10) chk("fair_rdata", bus.rsp_rdata, 8'hA5);
    end
    cyc();

    // W stalled 3 cycles while AW is accepted at once.
    sub_w_stall   = 3;
    bus.req_write = 2'b01;
    bus.req_addr  = {8'h00, 8'h40};
    bus.req_wdata = {8'h00, 8'hC3};
    bus.req_valid = 2'b01;
    #1;
    chk("ws_req_ready", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("ws_t1", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wready}, 3'b110);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("ws_stall", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wready}, 3'b010);
      chk("ws_wdata", bus.m_axi_wdata, 8'hC3);
    end
    cyc();
    chk("ws_t4", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wready}, 3'b011);
    cyc();
    chk("ws_t5", {bus.m_axi_wvalid, bus.rsp_valid}, 3'b000);
    cyc();
    chk("ws_rsp_t6", bus.rsp_valid, 2'b01);
    cyc();
    chk("ws_rsp_single", bus.rsp_valid, 2'b00);
    sub_w_stall = 0;

    // AR never accepted: timeout after 8 cycles.
    sub_arready   = 1'b0;
    bus.req_write = 2'b00;
    bus.req_addr  = {8'h50, 8'h00};
    bus.req_valid = 2'b10;
    #1;
    chk("to_req_ready", bus.req_ready, 2'b10);
    cyc();
    bus.req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_arvalid_hi", bus.m_axi_arvalid, 1'b1);
      cyc();
    end
    chk("to_arvalid_lo", {bus.m_axi_arvalid, bus.m_axi_rready}, 2'b00);
    chk("to_rsp_owner", bus.rsp_valid, 2'b10);
    chk("to_resp", bus.rsp_resp, 2'b11);
    sub_arready   = 1'b1;
    bus.req_write = 2'b01;
    bus.req_addr  = {8'h00, 8'h60};
    bus.req_wdata = {8'h00, 8'h77};
    bus.req_valid = 2'b01;
    #1;
    chk("to_idle_regrant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    cyc();
    chk("to_next_rsp", {bus.rsp_valid, bus.rsp_resp}, 4'b0100);

    // Reset while waiting for B.
    sub_b_block   = 1'b1;
    bus.req_addr  = {8'h00, 8'h70};
    bus.req_wdata = {8'h00, 8'h11};
    bus.req_valid = 2'b01;
    #1;
    chk("rr_req_ready", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk("rr_in_wr_resp", {bus.m_axi_bready, bus.m_axi_awvalid, bus.rsp_valid}, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("rr_ctrl_zero", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.m_axi_bready,
                         bus.m_axi_arvalid, bus.m_axi_rready, bus.req_ready, bus.rsp_valid,
                         bus.rsp_resp}, 12'h000);
    chk("rr_data_zero", {bus.rsp_rdata, bus.m_axi_awaddr, bus.m_axi_wdata}, 24'h0);
    cyc();
    rst_n       = 1'b1;
    sub_b_block = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rr_no_rsp", bus.rsp_valid, 2'b00);
    end
    bus.req_write = 2'b00;
    bus.req_addr  = {8'h10, 8'h20};
    bus.req_valid = 2'b11;
    #1;
    chk("rr_first_grant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    cyc();
    chk("rr_rsp_owner", bus.rsp_valid, 2'b01);
    chk("rr_rdata", bus.rsp_rdata, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_mgr_arb.md
Name: axi_mgr_arb

Overview:
- Two-requester arbiter and sequencer that shares one single-beat AXI manager port towards an axi_sub-style CSR subordinate.
- Each requester issues simple read or write commands. The block arbitrates round-robin and holds exactly one outstanding transaction.
- It drives AW+W or AR, then collects B or R. The response is routed back to the owning requester.
- A timeout counter aborts hung transactions.

Parameters:
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 8, address width.
- TIMEOUT_CYCLES, 255, cycles allowed per transaction before abort; 0 disables the timeout.

Ports:
- s_axi_clk  in  1  clock
- s_axi_resetn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid; bit i = requester i
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  write data, same packing as req_addr
- req_ready  out  2  command accepted (combinational)
- rsp_valid  out  2  one-cycle response pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_resp  out  2  AXI response code; 2'b11 on timeout
- m_axi_awaddr  out  ADDR_WIDTH
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_wlast  out  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- m_axi_rlast  in  1  ignored; all transactions are single-beat
- m_axi_rresp  in  2

Behaviour:
- Reset: state = IDLE, all valids/readies/rsp_* = 0, addr/data regs = 0, timeout counter = 0, last_grant = 1 (so requester 0 wins first). Reset takes effect immediately, mid-transaction included; the in-flight command is dropped with no rsp_valid.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE arbitration:
  - Grant g = the requester with req_valid set. If both are set, g = !last_grant.
  - req_ready[g] = 1 combinationally in that cycle.
  - On that edge: latch addr/wdata/write and owner = g; last_grant <= g; go to WR_ADDR or RD_ADDR.
  - req_ready is 0 in every non-IDLE state.
- WR_ADDR:
  - awvalid = wvalid = wlast = 1 from the first cycle. Each drops independently after its own valid&ready; W may complete before AW or vice versa.
  - bready = 1 (the subordinate only issues B while bready is high during the W handshake).
  - When both AW and W are done, go to WR_RESP. If bvalid arrives in the same cycle as the last handshake, complete directly.
- WR_RESP: bready = 1. On bvalid: rsp_resp <= bresp, rsp_valid[owner] pulses next cycle, go to IDLE.
- RD_ADDR: arvalid = 1 and rready = 1. On arvalid&arready, go to RD_DATA. An rvalid in this state or later completes the read.
- RD_DATA: rready = 1. On rvalid: rsp_rdata <= rdata, rsp_resp <= rresp, rsp_valid[owner] pulse, go to IDLE.
- Latency: accept at cycle T. AXI valids are high at T+1. Minimum rsp_valid is at T+3 (zero-wait subordinate).
- rsp_valid is registered and exactly one cycle wide. rsp_rdata/rsp_resp hold until the next response. The owner must keep req_valid low, or it re-arbitrates in IDLE; a new grant is possible in the same cycle rsp_valid is high.
- Timeout:
  - The counter clears on entry to any non-IDLE state and increments each non-IDLE cycle.
  - When count == TIMEOUT_CYCLES-1 with no completion, all m_axi valids/readies drop and rsp_resp = 2'b11. rsp_valid[owner] pulses and the FSM returns to IDLE.
  - Completion in the same cycle as the timeout wins (normal response).
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Test Plan:
- Req0 writes addr 0x10 data 0xA5 to a zero-wait subordinate -> req_ready[0] at T, awvalid/wvalid at T+1, bready high, rsp_valid[0] at T+3 with rsp_resp 0.
- Req1 reads addr 0x20, subordinate returns 0x3C -> araddr 0x20, rsp_rdata 0x3C, rsp_valid[1] only, rsp_resp 0.
- Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1 with exactly one outstanding transaction at any time.
- Subordinate holds wready low 3 cycles while awready = 1 -> awvalid drops after 1 cycle, wvalid holds 3 cycles with wdata stable, single rsp_valid.
- TIMEOUT_CYCLES = 8, subordinate never asserts arready -> arvalid high 8 cycles then low, rsp_resp 2'b11, FSM in IDLE.
- Assert s_axi_resetn low while in WR_RESP -> all outputs 0 immediately, no rsp_valid; after release, requester 0 wins the first simultaneous request.
